// File: rtl/mont_mul_lsu_arb.sv
// Shares one data-memory LSU port between the core and a mont_mul instance,
// holds the four operand base addresses and sequences mont_mul start/done.
module mont_mul_lsu_arb #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [1:0]  DATA_WORD = 2'b10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [ADDR_W-1:0] cfg_wdata,
  input  logic              cmd_start,
  output logic              cmd_busy,
  output logic              cmd_done,
  output logic              cfg_err,
  output logic              mm_start,
  input  logic              mm_done,
  input  logic              mm_ren,
  input  logic              mm_wen,
  input  logic [1:0]        mm_op_sel,
  input  logic [31:0]       mm_addr_offset,
  input  logic [31:0]       mm_wdata,
  output logic              mm_lsu_done,
  output logic [31:0]       mm_rdata,
  input  logic              core_ren,
  input  logic              core_wen,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [1:0]        core_type,
  input  logic [31:0]       core_wdata,
  output logic              core_done,
  output logic [31:0]       core_rdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_type,
  output logic [31:0]       mem_wdata,
  input  logic              mem_done,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} seq_e;
  typedef enum logic [1:0] {A_IDLE, A_CORE, A_MM} arb_e;

  seq_e              seq_q, seq_d;
  arb_e              arb_q, arb_d;
  logic              last_mm_q, last_mm_d;
  logic              cfg_err_q, cfg_err_d;
  logic [ADDR_W-1:0] base_q [4];
  logic [ADDR_W-1:0] base_d [4];
  logic              req_core, req_mm;
  logic [ADDR_W-1:0] mm_addr_abs;

  assign req_core    = core_ren | core_wen;
  assign req_mm      = mm_ren | mm_wen;
  assign mm_addr_abs = base_q[mm_op_sel] + ADDR_W'(mm_addr_offset);

  assign mm_start   = (seq_q == S_RUN);
  assign cmd_busy   = (seq_q != S_IDLE);
  assign cmd_done   = (seq_q == S_DONE);
  assign cfg_err    = cfg_err_q;
  assign core_rdata = mem_rdata;
  assign mm_rdata   = mem_rdata;

  // Sequencer and base registers: writes land at the same edge that leaves
  // S_IDLE, so an operation started alongside a write sees the new base.
  always_comb begin
    seq_d     = seq_q;
    base_d    = base_q;
    cfg_err_d = 1'b0;
    if (cfg_we) begin
      if (seq_q == S_IDLE) base_d[cfg_sel] = cfg_wdata;
      else                 cfg_err_d = 1'b1;
    end
    case (seq_q)
      S_IDLE:  if (cmd_start) seq_d = S_RUN;
      S_RUN:   if (mm_done)   seq_d = S_DONE;
      S_DONE:  seq_d = S_IDLE;
      default: seq_d = S_IDLE;
    endcase
  end

  always_comb begin
    arb_d       = arb_q;
    last_mm_d   = last_mm_q;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = '0;
    mem_type    = '0;
    mem_wdata   = '0;
    core_done   = 1'b0;
    mm_lsu_done = 1'b0;
    case (arb_q)
      A_IDLE: begin
        // On a tie the requester that did not own the port last time wins.
        if (req_core && (!req_mm || last_mm_q)) arb_d = A_CORE;
        else if (req_mm)                        arb_d = A_MM;
      end
      A_CORE: begin
        mem_ren   = core_ren;
        mem_wen   = core_wen;
        mem_addr  = core_addr;
        mem_type  = core_type;
        mem_wdata = core_wdata;
        core_done = mem_done;
        if (mem_done) begin
          last_mm_d = 1'b0;
          arb_d     = A_IDLE;
        end
      end
      A_MM: begin
        mem_wen     = mm_wen;
        mem_ren     = mm_ren & ~mm_wen;
        mem_addr    = mm_addr_abs;
        mem_type    = DATA_WORD;
        mem_wdata   = mm_wdata;
        mm_lsu_done = mem_done;
        if (mem_done) begin
          last_mm_d = 1'b1;
          arb_d     = A_IDLE;
        end
      end
      default: arb_d = A_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q     <= S_IDLE;
      arb_q     <= A_IDLE;
      last_mm_q <= 1'b1;
      cfg_err_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) base_q[i] <= '0;
    end else begin
      seq_q     <= seq_d;
      arb_q     <= arb_d;
      last_mm_q <= last_mm_d;
      cfg_err_q <= cfg_err_d;
      base_q    <= base_d;
    end
  end

endmodule

// File: tb/tb_mont_mul_lsu_arb.sv
// Directed bench for mont_mul_lsu_arb: a latency-configurable memory responder
// plus hand-driven core and mont_mul requesters.
`timescale 1ns/1ps
module tb_mont_mul_lsu_arb;
  localparam logic [1:0]  DW   = 2'b10;
  localparam logic [31:0] RD_X = 32'h5A5A_0000;

  logic        clk = 1'b0, rst;
  logic        cfg_we, cmd_start, mm_done, mm_ren, mm_wen, core_ren, core_wen, mem_done;
  logic [1:0]  cfg_sel, mm_op_sel, core_type;
  logic [31:0] cfg_wdata, mm_addr_offset, mm_wdata, core_addr, core_wdata, mem_rdata;
  logic        cmd_busy, cmd_done, cfg_err, mm_start, mm_lsu_done, core_done, mem_ren, mem_wen;
  logic [31:0] mm_rdata, core_rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_type;

  always #5 clk = ~clk;

  mont_mul_lsu_arb #(.ADDR_W(32), .DATA_WORD(DW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .cmd_start(cmd_start), .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cfg_err(cfg_err),
    .mm_start(mm_start), .mm_done(mm_done), .mm_ren(mm_ren), .mm_wen(mm_wen),
    .mm_op_sel(mm_op_sel), .mm_addr_offset(mm_addr_offset), .mm_wdata(mm_wdata),
    .mm_lsu_done(mm_lsu_done), .mm_rdata(mm_rdata), .core_ren(core_ren), .core_wen(core_wen),
    .core_addr(core_addr), .core_type(core_type), .core_wdata(core_wdata),
    .core_done(core_done), .core_rdata(core_rdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_type(mem_type), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  int checks = 0, errors = 0;
  int lat = 1, resp_cnt = 0, done_pulses = 0;
  int order[$];
  bit mm_fin;

  typedef struct {
    logic        is_mm;
    logic        ren;
    logic        wen;
    logic [1:0]  sel_type;
    logic [31:0] addr_off;
    logic [31:0] wdata;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: completes an access `lat` cycles after it appears.
  initial begin
    mem_done = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_done) begin mem_done = 1'b0; resp_cnt = 0; end
      else if (mem_ren || mem_wen) begin
        resp_cnt++;
        if (resp_cnt >= lat) begin mem_done = 1'b1; mem_rdata = mem_addr ^ RD_X; end
      end else resp_cnt = 0;
    end
  end

  initial forever begin
    @(negedge clk); #2;
    if (cmd_done === 1'b1) done_pulses++;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mont1(input longint a, input longint b, input longint n);
    longint x;
    x = (a * b) % n;
    for (int i = 0; i < 32; i++) x = (x % 2 == 1) ? (x + n) / 2 : x / 2;
    return x[31:0];
  endfunction

  task automatic core_xfer(input logic w, input logic [31:0] a, input logic [1:0] t,
                           input logic [31:0] wd, input logic [31:0] exp_a, output int waited);
    core_ren = !w; core_wen = w; core_addr = a; core_type = t; core_wdata = wd;
    waited = 0;
    do begin @(negedge clk); waited++; end while (core_done !== 1'b1 && waited < 200);
    chk("core_done", core_done, 1);
    chk("core_mem_addr", mem_addr, exp_a);
    chk("core_mem_type", mem_type, t);
    chk("core_mem_wen", mem_wen, w);
    chk("core_mem_ren", mem_ren, !w);
    chk("core_mem_wdata", mem_wdata, wd);
    chk("core_rdata", core_rdata, exp_a ^ RD_X);
    chk("core_mm_done_quiet", mm_lsu_done, 0);
    order.push_back(0);
    core_ren = 1'b0; core_wen = 1'b0;
  endtask

  task automatic mm_xfer(input logic r, input logic w, input logic [1:0] sel, input logic [31:0] off,
                         input logic [31:0] wd, input logic [31:0] exp_a, output int waited);
    mm_ren = r; mm_wen = w; mm_op_sel = sel; mm_addr_offset = off; mm_wdata = wd;
    waited = 0;
    do begin @(negedge clk); waited++; end while (mm_lsu_done !== 1'b1 && waited < 200);
    chk("mm_lsu_done", mm_lsu_done, 1);
    chk("mm_mem_addr", mem_addr, exp_a);
    chk("mm_mem_type", mem_type, DW);
    chk("mm_mem_wen", mem_wen, w);
    chk("mm_mem_ren", mem_ren, r && !w);
    chk("mm_mem_wdata", mem_wdata, wd);
    chk("mm_rdata", mm_rdata, exp_a ^ RD_X);
    chk("mm_core_done_quiet", core_done, 0);
    order.push_back(1);
    mm_ren = 1'b0; mm_wen = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [31:0] d, input logic exp_err);
    cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    chk("cfg_err", cfg_err, exp_err);
  endtask

  task automatic start_op();
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    chk("start_mm_start", mm_start, 1);
    chk("start_busy", cmd_busy, 1);
  endtask

  task automatic finish_op();
    mm_done = 1'b1;
    @(negedge clk);
    mm_done = 1'b0;
    chk("fin_cmd_done", cmd_done, 1);
    chk("fin_mm_start", mm_start, 0);
    chk("fin_busy", cmd_busy, 1);
    @(negedge clk);
    chk("fin_done_cleared", cmd_done, 0);
    chk("fin_idle", cmd_busy, 0);
  endtask

  initial begin
    int wt, wt_a, wt_b, maxw, p0;
    logic [31:0] r_val;
    bit seen;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_1234, 32'h0,         32'h0000_1234};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 2'd1, 32'h8000_0004, 32'hDEAD_BEEF, 32'h8000_0004};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_2000, 32'h0,         32'h0000_2000};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_0008, 32'h0,         32'h0000_0108};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 2'd1, 32'h0000_0020, 32'h0,         32'h0000_0220};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 2'd3, 32'h0000_0010, 32'h1234_5678, 32'h0000_0008};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 2'd2, 32'h0000_0000, 32'h0000_CAFE, 32'h0000_0300};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'hFFFF_FFFC, 32'h0,         32'h0000_00FC};

    rst = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_wdata = '0; cmd_start = 1'b0; mm_done = 1'b0;
    mm_ren = 1'b0; mm_wen = 1'b0; mm_op_sel = '0; mm_addr_offset = '0; mm_wdata = '0;
    core_ren = 1'b0; core_wen = 1'b0; core_addr = '0; core_type = '0; core_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_ren", mem_ren, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_type", mem_type, 0);
    chk("rst_busy", cmd_busy, 0);
    chk("rst_cmd_done", cmd_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_mm_start", mm_start, 0);
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous requests from reset: core first, then strict alternation.
    order.delete();
    fork
      begin for (int i = 0; i < 3; i++) core_xfer(1'b0, 32'h40 + 4*i, 2'd2, '0, 32'h40 + 4*i, wt_a); end
      begin for (int i = 0; i < 3; i++) mm_xfer(1'b1, 1'b0, 2'd0, 4*i, '0, 4*i, wt_b); end
    join
    chk("t2_order_len", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++) chk("t2_order", order[i], i % 2);

    cfg_write(2'd0, 32'h0000_0100, 1'b0);
    cfg_write(2'd1, 32'h0000_0200, 1'b0);
    cfg_write(2'd2, 32'h0000_0300, 1'b0);
    cfg_write(2'd3, 32'hFFFF_FFF8, 1'b0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_mm)
        mm_xfer(vecs[i].ren, vecs[i].wen, vecs[i].sel_type, vecs[i].addr_off, vecs[i].wdata,
                vecs[i].exp_addr, wt);
      else
        core_xfer(vecs[i].wen, vecs[i].addr_off, vecs[i].sel_type, vecs[i].wdata,
                  vecs[i].exp_addr, wt);
      @(negedge clk);
    end

    // Fairness under a long MM burst with slow memory.
    lat = 3; mm_fin = 1'b0; maxw = 0;
    fork
      begin
        for (int i = 0; i < 50; i++) mm_xfer(1'b1, 1'b0, 2'd1, 4*(i%4), '0, 32'h200 + 4*(i%4), wt_a);
        mm_fin = 1'b1;
      end
      begin
        while (!mm_fin) begin
          core_xfer(1'b0, 32'h5000, 2'd2, '0, 32'h5000, wt_b);
          if (wt_b > maxw) maxw = wt_b;
        end
      end
    join
    checks++;
    if (maxw > 10) begin errors++; $display("FAIL t3_core_wait: got %0d cycles, limit 10", maxw); end
    lat = 1;
    @(negedge clk);

    // Full operation; the A write in the start cycle must be honoured.
    cfg_write(2'd3, 32'h0000_0400, 1'b0);
    cfg_write(2'd2, 32'h0000_0777, 1'b0);
    p0 = done_pulses;
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_wdata = 32'h0000_0300;
    start_op();
    cfg_we = 1'b0;
    chk("t1_cfg_err_idle", cfg_err, 0);
    r_val = mont1(3, 5, 7);
    for (int i = 0; i < 4; i++) mm_xfer(1'b1, 1'b0, 2'd0, 4*i, '0, 32'h100 + 4*i, wt);
    for (int i = 0; i < 4; i++) mm_xfer(1'b1, 1'b0, 2'd1, 4*i, '0, 32'h200 + 4*i, wt);
    mm_xfer(1'b1, 1'b0, 2'd2, 32'h0, '0, 32'h300, wt);
    for (int i = 0; i < 4; i++)
      mm_xfer(1'b0, 1'b1, 2'd3, 4*i, (i == 0) ? r_val : 32'h0, 32'h400 + 4*i, wt);
    finish_op();
    @(negedge clk);
    chk("t1_done_pulses", done_pulses - p0, 1);

    // Config write while busy is rejected.
    start_op();
    cfg_write(2'd2, 32'h0000_0999, 1'b1);
    @(negedge clk);
    chk("t4_cfg_err_pulse", cfg_err, 0);
    mm_xfer(1'b1, 1'b0, 2'd2, 32'h0, '0, 32'h300, wt);
    finish_op();
    mm_xfer(1'b1, 1'b0, 2'd2, 32'h4, '0, 32'h304, wt);

    // cmd_start held: one done per operation, restart after S_DONE.
    p0 = done_pulses;
    cmd_start = 1'b1;
    @(negedge clk);
    chk("t6_mm_start", mm_start, 1);
    repeat (3) @(negedge clk);
    chk("t6_busy_held", cmd_busy, 1);
    mm_done = 1'b1;
    @(negedge clk);
    mm_done = 1'b0;
    chk("t6_cmd_done", cmd_done, 1);
    @(negedge clk);
    chk("t6_idle_gap", cmd_busy, 0);
    chk("t6_single_done", cmd_done, 0);
    @(negedge clk);
    chk("t6_restart", mm_start, 1);
    cmd_start = 1'b0;
    finish_op();
    @(negedge clk);
    chk("t6_done_pulses", done_pulses - p0, 2);

    // Reset while MM owns the port mid-access.
    lat = 20;
    start_op();
    mm_ren = 1'b1; mm_wen = 1'b0; mm_op_sel = 2'd0; mm_addr_offset = 32'h0;
    wt = 0;
    while (mem_ren !== 1'b1 && wt < 20) begin @(negedge clk); wt++; end
    chk("t5_owned", mem_ren, 1);
    p0 = done_pulses;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_mem_ren", mem_ren, 0);
    chk("t5_busy", cmd_busy, 0);
    chk("t5_mm_start", mm_start, 0);
    rst = 1'b0; mm_ren = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (cmd_done || mm_lsu_done || core_done) seen = 1'b1;
    end
    chk("t5_no_done", seen, 0);
    chk("t5_no_cmd_done", done_pulses - p0, 0);
    lat = 1;
    mm_xfer(1'b1, 1'b0, 2'd3, 32'h10, '0, 32'h10, wt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
